// File: rtl/seg7_rx_decoder.sv
// Receive-side seven-segment decoder: stability filter plus glyph-to-hex decode.
// Optional bad-pattern counter enabled by defining SEG7_RX_ERRCNT_EN.
module seg7_rx_decoder #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 16,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_i,
  output logic [3:0]       digit,
  output logic             digit_ok,
  output logic             blank,
  output logic             bad,
  output logic             upd,
  output logic [7:0]       upd_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       seg_q;
  logic [6:0]       acc_seg;
  logic [CNT_W-1:0] stab_cnt;
  logic             armed;
  logic             accept;
  logic             changed;
  logic [3:0]       dec_val;
  logic             dec_ok;

  // seg_q equals seg_i at the accepting edge, so decoding seg_q is safe.
  always_comb begin
    dec_val = 4'h0;
    dec_ok  = 1'b1;
    case (seg_q)
      7'h7E: dec_val = 4'h0;
      7'h30: dec_val = 4'h1;
      7'h6D: dec_val = 4'h2;
      7'h79: dec_val = 4'h3;
      7'h33: dec_val = 4'h4;
      7'h5B: dec_val = 4'h5;
      7'h5F: dec_val = 4'h6;
      7'h70: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h7B: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h1F: dec_val = 4'hB;
      7'h4E: dec_val = 4'hC;
      7'h3D: dec_val = 4'hD;
      7'h4F: dec_val = 4'hE;
      7'h47: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  assign accept  = armed && (seg_i == seg_q) && (stab_cnt == STAB_LAST);
  assign changed = (seg_q != acc_seg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= 7'h00;
      stab_cnt <= '0;
      acc_seg  <= 7'h00;
      armed    <= 1'b1;
      digit    <= 4'h0;
      digit_ok <= 1'b0;
      blank    <= 1'b0;
      bad      <= 1'b0;
      upd      <= 1'b0;
      upd_cnt  <= 8'h00;
    end else begin
      seg_q <= seg_i;
      upd   <= 1'b0;
      if (seg_i != seg_q) begin
        stab_cnt <= '0;
        armed    <= 1'b1;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
      // One acceptance per stable run; armed is only re-set by a change.
      if (accept) begin
        armed    <= 1'b0;
        acc_seg  <= seg_q;
        upd      <= changed;
        digit_ok <= dec_ok;
        blank    <= (seg_q == 7'h00);
        bad      <= !dec_ok && (seg_q != 7'h00);
        if (changed) upd_cnt <= upd_cnt + 8'd1;
        if (dec_ok)  digit   <= dec_val;
      end
    end
  end

`ifdef SEG7_RX_ERRCNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && !dec_ok && (seg_q != 7'h00) && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Bench for seg7_rx_decoder: directed scenarios plus random holds, checked against
// a run-length reference model of the acceptance rule.
module tb_seg7_rx_decoder;

  localparam int S     = 3;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       seg_i = 7'h00;
  logic [3:0]       digit;
  logic             digit_ok, blank, bad, upd;
  logic [7:0]       upd_cnt;
  logic [ERR_W-1:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int pulses;

  seg7_rx_decoder #(.STABLE_CYCLES(S), .CNT_W(16), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .seg_i(seg_i), .digit(digit), .digit_ok(digit_ok),
    .blank(blank), .bad(bad), .upd(upd), .upd_cnt(upd_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model: a pattern is accepted when it has been sampled S+1 times in a row.
  logic [6:0] m_last, m_acc;
  int         m_run, m_digit, m_ok, m_blank, m_bad, m_upd, m_updcnt, m_err;

  task automatic model_reset();
    m_last = 7'h00; m_run = 1; m_acc = 7'h00;
    m_digit = 0; m_ok = 0; m_blank = 0; m_bad = 0; m_upd = 0; m_updcnt = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic [6:0] v);
    int idx;
    if (v == m_last) m_run++;
    else m_run = 1;
    m_last = v;
    m_upd  = 0;
    if (m_run == S + 1) begin
      idx = -1;
      for (int i = 0; i < 16; i++) if (glyph[i] == v) idx = i;
      m_ok    = (idx >= 0);
      m_blank = (v == 7'h00);
      m_bad   = (idx < 0) && (v != 7'h00);
      if (idx >= 0) m_digit = idx;
      if (v != m_acc) begin
        m_upd = 1;
        m_updcnt = (m_updcnt + 1) % 256;
      end
`ifdef SEG7_RX_ERRCNT_EN
      if (m_bad && m_err < (1 << ERR_W) - 1) m_err++;
`endif
      m_acc = v;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_digit"},    32'(digit),    32'(m_digit));
    chk({tag, "_digit_ok"}, 32'(digit_ok), 32'(m_ok));
    chk({tag, "_blank"},    32'(blank),    32'(m_blank));
    chk({tag, "_bad"},      32'(bad),      32'(m_bad));
    chk({tag, "_upd"},      32'(upd),      32'(m_upd));
    chk({tag, "_upd_cnt"},  32'(upd_cnt),  32'(m_updcnt));
    chk({tag, "_err_cnt"},  32'(err_cnt),  32'(m_err));
  endtask

  // Drive one value for one clock edge, then check every output 1 ns after the edge.
  task automatic step(input string tag, input logic [6:0] v);
    seg_i = v;
    @(posedge clk);
    model_edge(v);
    #1;
    if (upd) pulses++;
    chk_all(tag);
  endtask

  task automatic hold(input string tag, input logic [6:0] v, input int n);
    for (int i = 0; i < n; i++) step(tag, v);
  endtask

  logic [3:0] snap_digit;
  int         snap_cnt, p0, e0, hlen;
  logic [6:0] rv;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");

    // 1: 7E held; accepted on the edge S after its first sampling
    seg_i = 7'h7E;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    hold("t1", 7'h7E, S);
    chk("t1_pre_ok", 32'(digit_ok), 32'd0);
    step("t1", 7'h7E);
    chk("t1_digit", 32'(digit), 32'd0);
    chk("t1_ok", 32'(digit_ok), 32'd1);
    chk("t1_upd", 32'(upd), 32'd1);
    chk("t1_upd_cnt", 32'(upd_cnt), 32'd1);
    step("t1", 7'h7E);
    chk("t1_upd_once", 32'(pulses), 32'd1);

    // 2: 0->1->2 display cycle twice
    pulses = 0;
    p0 = int'(upd_cnt);
    for (int r = 0; r < 2; r++) begin
      hold("t2", 7'h7E, 5);
      chk("t2_d0", 32'(digit), 32'd0);
      hold("t2", 7'h30, 5);
      chk("t2_d1", 32'(digit), 32'd1);
      hold("t2", 7'h6D, 5);
      chk("t2_d2", 32'(digit), 32'd2);
    end
    chk("t2_pulses", 32'(pulses), 32'd5);
    chk("t2_upd_cnt", 32'(upd_cnt), 32'((p0 + 5) % 256));

    // 3: one-cycle glitch on an accepted 30 changes nothing
    hold("t3", 7'h30, 5);
    snap_digit = digit;
    snap_cnt = int'(upd_cnt);
    pulses = 0;
    step("t3", 7'h31);
    hold("t3", 7'h30, 6);
    chk("t3_pulses", 32'(pulses), 32'd0);
    chk("t3_digit", 32'(digit), 32'(snap_digit));
    chk("t3_upd_cnt", 32'(upd_cnt), 32'(snap_cnt));

    // 4: illegal pattern 01, then the same bad pattern again after a glitch
    e0 = int'(err_cnt);
    hold("t4", 7'h01, 5);
    chk("t4_bad", 32'(bad), 32'd1);
    chk("t4_ok", 32'(digit_ok), 32'd0);
    chk("t4_digit", 32'(digit), 32'd1);
`ifdef SEG7_RX_ERRCNT_EN
    chk("t4_err", 32'(err_cnt), 32'(e0 + 1));
`else
    chk("t4_err", 32'(err_cnt), 32'd0);
`endif
    step("t4", 7'h02);
    hold("t4", 7'h01, 5);

    // 5: reset mid-run, release with blank held
    hold("t5", 7'h5B, 2);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("t5_rst");
    seg_i = 7'h00;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    hold("t5", 7'h00, 5);
    chk("t5_blank", 32'(blank), 32'd1);
    chk("t5_pulses", 32'(pulses), 32'd0);

    // 6: 256 alternating acceptances wrap upd_cnt
    p0 = int'(upd_cnt);
    for (int i = 0; i < 256; i++) hold("t6", (i % 2 == 0) ? 7'h7E : 7'h30, S + 1);
    chk("t6_wrap", 32'(upd_cnt), 32'(p0));

    // 7: random patterns with random hold lengths, including sub-threshold glitches
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1: rv = glyph[$urandom_range(0, 15)];
        2:    rv = 7'h00;
        default: rv = 7'($urandom_range(0, 127));
      endcase
      hlen = $urandom_range(1, S + 3);
      hold("rnd", rv, hlen);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
